// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine-mode CSR file plus exception / timer-interrupt / MRET / WFI sequencing.
// Redirects toward fetch are registered and pulse for exactly one cycle per event.
module trap_csr_unit #(
  parameter logic [31:0] HART_ID   = 32'd0,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] pc_i,
  input  logic        exc_request,
  input  logic [31:0] exc_cause,
  input  logic        exc_ret,
  input  logic        wfi,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  input  logic        timer_irq,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  output logic        pc_redirect,
  output logic [31:0] pc_target,
  output logic        trap_taken,
  output logic        stall
);
  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WFI = 1'b1} state_t;

  localparam logic [31:0] MISA_VAL  = 32'h4000_0100;
  localparam logic [31:0] IRQ_CAUSE = 32'h8000_0007;

  state_t      stateR, stateNextS;
  logic        mstatusMieR, mstatusMpieR, mieMtieR;
  logic [31:0] mepcR, mcauseR, mscratchR, mtvecR;
  logic [63:0] mcycleR, minstretR;
  logic        pcRedirectR, trapTakenR, stallR;
  logic [31:0] pcTargetR;

  logic [31:0] rdataS, csrNewS, trapCauseS, trapEpcS, trapTargetS;
  logic        knownS, roS, illegalS, wakeS, irqPendS;
  logic        takeTrapS, isIrqS, doMretS, doCsrS, retireS;
  logic        wrCycLoS, wrCycHiS, wrInsLoS, wrInsHiS;
  logic [63:0] mcycleIncS, minstretIncS, mcycleNextS, minstretNextS;

  // CSR read mux and address classification
  always_comb begin
    rdataS = 32'd0;
    knownS = 1'b1;
    roS    = 1'b0;
    case (csr_addr)
      12'h300: rdataS = {19'd0, 2'b11, 3'd0, mstatusMpieR, 3'd0, mstatusMieR, 3'd0};
      12'h301: begin rdataS = MISA_VAL; roS = 1'b1; end
      12'h304: rdataS = {24'd0, mieMtieR, 7'd0};
      12'h305: rdataS = mtvecR;
      12'h340: rdataS = mscratchR;
      12'h341: rdataS = mepcR;
      12'h342: rdataS = mcauseR;
      12'h344: begin rdataS = {24'd0, timer_irq, 7'd0}; roS = 1'b1; end
      12'hB00: rdataS = mcycleR[31:0];
      12'hB80: rdataS = mcycleR[63:32];
      12'hB02: rdataS = minstretR[31:0];
      12'hB82: rdataS = minstretR[63:32];
      12'hF14: begin rdataS = HART_ID; roS = 1'b1; end
      default: knownS = 1'b0;
    endcase
  end

  // Set/clear with a zero operand is a pure read, so it stays legal on read-only CSRs
  assign illegalS = (csr_op != 2'd0) &&
                    (!knownS || (roS && ((csr_op == 2'd1) || (csr_wdata != 32'd0))));

  // Read-modify-write value for the addressed CSR
  always_comb begin
    csrNewS = rdataS;
    case (csr_op)
      2'd1:    csrNewS = csr_wdata;
      2'd2:    csrNewS = rdataS | csr_wdata;
      2'd3:    csrNewS = rdataS & ~csr_wdata;
      default: csrNewS = rdataS;
    endcase
  end

  assign wakeS    = mieMtieR & timer_irq;
  assign irqPendS = mstatusMieR & wakeS;

  // Event arbitration and next state
  always_comb begin
    stateNextS = stateR;
    takeTrapS  = 1'b0;
    isIrqS     = 1'b0;
    doMretS    = 1'b0;
    doCsrS     = 1'b0;
    retireS    = 1'b0;
    trapCauseS = 32'd0;
    trapEpcS   = pc_i;
    case (stateR)
      ST_RUN: begin
        if (!instr_valid) begin
          stateNextS = ST_RUN;
        end else if (exc_request || illegalS) begin
          takeTrapS  = 1'b1;
          trapCauseS = exc_request ? exc_cause : 32'd2;
        end else if (irqPendS) begin
          takeTrapS  = 1'b1;
          isIrqS     = 1'b1;
          trapCauseS = IRQ_CAUSE;
        end else begin
          retireS = 1'b1;
          if (exc_ret) begin
            doMretS = 1'b1;
          end else if (wfi) begin
            stateNextS = ST_WFI;
          end else begin
            doCsrS = (csr_op != 2'd0);
          end
        end
      end
      ST_WFI: begin
        if (!wakeS) begin
          stateNextS = ST_WFI;
        end else if (irqPendS) begin
          // The WFI itself has completed, so the return point is the next instruction
          stateNextS = ST_RUN;
          takeTrapS  = 1'b1;
          isIrqS     = 1'b1;
          trapCauseS = IRQ_CAUSE;
          trapEpcS   = pc_i + 32'd4;
        end else begin
          stateNextS = ST_RUN;
        end
      end
      default: stateNextS = ST_RUN;
    endcase
  end

  assign trapTargetS = {mtvecR[31:2], 2'b00} +
                       ((isIrqS && (mtvecR[1:0] == 2'b01)) ? 32'd28 : 32'd0);

  // A write to one counter half suppresses the carry into the other half on that edge
  assign wrCycLoS     = doCsrS && (csr_addr == 12'hB00);
  assign wrCycHiS     = doCsrS && (csr_addr == 12'hB80);
  assign wrInsLoS     = doCsrS && (csr_addr == 12'hB02);
  assign wrInsHiS     = doCsrS && (csr_addr == 12'hB82);
  assign mcycleIncS   = mcycleR + 64'd1;
  assign minstretIncS = minstretR + {63'd0, retireS};
  assign mcycleNextS  = {wrCycHiS ? csrNewS : (wrCycLoS ? mcycleR[63:32] : mcycleIncS[63:32]),
                         wrCycLoS ? csrNewS : mcycleIncS[31:0]};
  assign minstretNextS = {wrInsHiS ? csrNewS : (wrInsLoS ? minstretR[63:32] : minstretIncS[63:32]),
                          wrInsLoS ? csrNewS : minstretIncS[31:0]};

  // Architectural CSR state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mstatusMieR  <= 1'b0;
      mstatusMpieR <= 1'b0;
      mieMtieR     <= 1'b0;
      mepcR        <= 32'd0;
      mcauseR      <= 32'd0;
      mscratchR    <= 32'd0;
      mtvecR       <= MTVEC_RST;
      mcycleR      <= 64'd0;
      minstretR    <= 64'd0;
    end else begin
      if (takeTrapS) begin
        mepcR        <= trapEpcS & 32'hFFFF_FFFC;
        mcauseR      <= trapCauseS;
        mstatusMpieR <= mstatusMieR;
        mstatusMieR  <= 1'b0;
      end else if (doMretS) begin
        mstatusMieR  <= mstatusMpieR;
        mstatusMpieR <= 1'b1;
      end else if (doCsrS) begin
        case (csr_addr)
          12'h300: begin
            mstatusMieR  <= csrNewS[3];
            mstatusMpieR <= csrNewS[7];
          end
          12'h304: mieMtieR  <= csrNewS[7];
          12'h305: mtvecR    <= csrNewS;
          12'h340: mscratchR <= csrNewS;
          12'h341: mepcR     <= csrNewS & 32'hFFFF_FFFC;
          12'h342: mcauseR   <= csrNewS;
          default: mcauseR   <= mcauseR;
        endcase
      end
      mcycleR   <= mcycleNextS;
      minstretR <= minstretNextS;
    end
  end

  // FSM state and registered fetch-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR      <= ST_RUN;
      pcRedirectR <= 1'b0;
      trapTakenR  <= 1'b0;
      stallR      <= 1'b0;
      pcTargetR   <= 32'd0;
    end else begin
      stateR      <= stateNextS;
      pcRedirectR <= takeTrapS | doMretS;
      trapTakenR  <= takeTrapS;
      stallR      <= (stateNextS == ST_WFI);
      if (takeTrapS) begin
        pcTargetR <= trapTargetS;
      end else if (doMretS) begin
        pcTargetR <= mepcR;
      end
    end
  end

  assign csr_rdata   = rdataS;
  assign illegal_csr = illegalS;
  assign pc_redirect = pcRedirectR;
  assign pc_target   = pcTargetR;
  assign trap_taken  = trapTakenR;
  assign stall       = stallR;
endmodule

// File: tb/tb_trap_csr_unit.sv
// Bench for trap_csr_unit: directed scenarios followed by random traffic, all checked
// against a CSR-map reference model built from the architectural rules.
module tb_trap_csr_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] pc_i;
  logic        exc_request;
  logic [31:0] exc_cause;
  logic        exc_ret;
  logic        wfi;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        timer_irq;
  logic [31:0] csr_rdata;
  logic        illegal_csr;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        trap_taken;
  logic        stall;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model: flat CSR map with per-address writable mask and fixed bits
  logic [31:0] mVal   [0:4095];
  logic [31:0] mMask  [0:4095];
  logic [31:0] mFixed [0:4095];
  bit          mKnown [0:4095];
  bit          mRo    [0:4095];
  logic [63:0] mCycle, mInstret;
  bit          mSleep;
  logic        expRedirect, expTrap;
  logic [31:0] expTarget;

  logic [11:0] addrTab [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                12'h342, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                12'hF14, 12'h7C0, 12'h345, 12'h300};

  trap_csr_unit #(.HART_ID(32'd0), .MTVEC_RST(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .pc_i(pc_i),
    .exc_request(exc_request), .exc_cause(exc_cause), .exc_ret(exc_ret), .wfi(wfi),
    .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .timer_irq(timer_irq),
    .csr_rdata(csr_rdata), .illegal_csr(illegal_csr), .pc_redirect(pc_redirect),
    .pc_target(pc_target), .trap_taken(trap_taken), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic defCsr(input logic [11:0] a, input logic [31:0] val, input logic [31:0] mask,
                        input logic [31:0] fixed, input bit ro);
    mVal[a] = val; mMask[a] = mask; mFixed[a] = fixed; mKnown[a] = 1'b1; mRo[a] = ro;
  endtask

  task automatic modelReset();
    for (int a = 0; a < 4096; a++) begin
      mVal[a] = 32'd0; mMask[a] = 32'd0; mFixed[a] = 32'd0; mKnown[a] = 1'b0; mRo[a] = 1'b0;
    end
    defCsr(12'h300, 32'd0, 32'h0000_0088, 32'h0000_1800, 1'b0);
    defCsr(12'h301, 32'd0, 32'd0, 32'h4000_0100, 1'b1);
    defCsr(12'h304, 32'd0, 32'h0000_0080, 32'd0, 1'b0);
    defCsr(12'h305, 32'h0000_0100, 32'hFFFF_FFFF, 32'd0, 1'b0);
    defCsr(12'h340, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    defCsr(12'h341, 32'd0, 32'hFFFF_FFFC, 32'd0, 1'b0);
    defCsr(12'h342, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0);
    defCsr(12'h344, 32'd0, 32'd0, 32'd0, 1'b1);
    defCsr(12'hB00, 32'd0, 32'd0, 32'd0, 1'b0);
    defCsr(12'hB80, 32'd0, 32'd0, 32'd0, 1'b0);
    defCsr(12'hB02, 32'd0, 32'd0, 32'd0, 1'b0);
    defCsr(12'hB82, 32'd0, 32'd0, 32'd0, 1'b0);
    defCsr(12'hF14, 32'd0, 32'd0, 32'd0, 1'b1);
    mCycle = 64'd0; mInstret = 64'd0; mSleep = 1'b0;
    expRedirect = 1'b0; expTrap = 1'b0; expTarget = 32'd0;
  endtask

  function automatic logic [31:0] mRead(input logic [11:0] a);
    case (a)
      12'hB00: return mCycle[31:0];
      12'hB80: return mCycle[63:32];
      12'hB02: return mInstret[31:0];
      12'hB82: return mInstret[63:32];
      12'h344: return timer_irq ? 32'h0000_0080 : 32'd0;
      default: return (mVal[a] & mMask[a]) | mFixed[a];
    endcase
  endfunction

  function automatic bit mIllegal(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
    return (op != 2'd0) && (!mKnown[a] || (mRo[a] && (op == 2'd1 || wd != 32'd0)));
  endfunction

  // Advance the model by one clock edge using the currently driven inputs
  task automatic modelStep();
    logic [31:0] old, nv, epc, cause;
    logic [63:0] cyc, ins;
    bit mieBit, wake, pend, trap, irq, mret, csrDo, retire;
    mieBit = mVal[12'h300][3];
    wake = mVal[12'h304][7] && timer_irq;
    pend = mieBit && wake;
    trap = 0; irq = 0; mret = 0; csrDo = 0; retire = 0; epc = pc_i; cause = 32'd0;
    if (mSleep) begin
      if (wake) begin
        mSleep = 1'b0;
        if (pend) begin trap = 1; irq = 1; epc = pc_i + 32'd4; end
      end
    end else if (instr_valid) begin
      if (exc_request) begin trap = 1; cause = exc_cause; end
      else if (mIllegal(csr_op, csr_addr, csr_wdata)) begin trap = 1; cause = 32'd2; end
      else if (pend) begin trap = 1; irq = 1; end
      else begin
        retire = 1;
        if (exc_ret) mret = 1;
        else if (wfi) mSleep = 1'b1;
        else csrDo = (csr_op != 2'd0);
      end
    end
    if (irq) cause = 32'h8000_0007;
    old = mRead(csr_addr);
    case (csr_op)
      2'd1:    nv = csr_wdata;
      2'd2:    nv = old | csr_wdata;
      2'd3:    nv = old & ~csr_wdata;
      default: nv = old;
    endcase
    cyc = mCycle + 64'd1;
    ins = mInstret + 64'(retire);
    if (csrDo) begin
      case (csr_addr)
        12'hB00: cyc = {mCycle[63:32], nv};
        12'hB80: cyc[63:32] = nv;
        12'hB02: ins = {mInstret[63:32], nv};
        12'hB82: ins[63:32] = nv;
        default: if (!mRo[csr_addr]) mVal[csr_addr] = nv;
      endcase
    end
    mCycle = cyc; mInstret = ins;
    expRedirect = trap || mret;
    expTrap = trap;
    if (trap) begin
      expTarget = {mVal[12'h305][31:2], 2'b00} +
                  ((irq && mVal[12'h305][1:0] == 2'b01) ? 32'd28 : 32'd0);
      mVal[12'h341] = epc;
      mVal[12'h342] = cause;
      mVal[12'h300][7] = mieBit;
      mVal[12'h300][3] = 1'b0;
    end else if (mret) begin
      expTarget = mRead(12'h341);
      mVal[12'h300][3] = mVal[12'h300][7];
      mVal[12'h300][7] = 1'b1;
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] pc, input logic er, input logic [31:0] cause,
                       input logic ret, input logic w, input logic [1:0] op, input logic [11:0] addr,
                       input logic [31:0] wd);
    instr_valid = iv; pc_i = pc; exc_request = er; exc_cause = cause; exc_ret = ret; wfi = w;
    csr_op = op; csr_addr = addr; csr_wdata = wd;
  endtask

  task automatic step(input string tag);
    #2;
    chk($sformatf("%s.rdata", tag), csr_rdata, mRead(csr_addr));
    chk($sformatf("%s.illegal", tag), 32'(illegal_csr), 32'(mIllegal(csr_op, csr_addr, csr_wdata)));
    modelStep();
    @(posedge clk);
    #1;
    chk($sformatf("%s.redirect", tag), 32'(pc_redirect), 32'(expRedirect));
    chk($sformatf("%s.target", tag), pc_target, expTarget);
    chk($sformatf("%s.trap", tag), 32'(trap_taken), 32'(expTrap));
    chk($sformatf("%s.stall", tag), 32'(stall), 32'(mSleep));
  endtask

  task automatic peek(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_op = 2'd0; csr_addr = addr;
    #1;
    chk(tag, csr_rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    timer_irq = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 12'h000, 32'd0);
    modelReset();
    @(negedge clk);
    chk("rst.redirect", 32'(pc_redirect), 32'd0);
    chk("rst.target", pc_target, 32'd0);
    chk("rst.trap", 32'(trap_taken), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    peek("rst.mtvec", 12'h305, 32'h0000_0100);
    peek("rst.mstatus", 12'h300, 32'h0000_1800);
    peek("rst.misa", 12'h301, 32'h4000_0100);
    peek("rst.mhartid", 12'hF14, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ECALL with MIE set, then MRET back
    drive(1'b1, 32'h1FC, 1'b0, 32'd0, 1'b0, 1'b0, 2'd2, 12'h300, 32'h8); step("setmie");
    drive(1'b1, 32'h200, 1'b1, 32'd11, 1'b0, 1'b0, 2'd0, 12'h000, 32'd0); step("ecall");
    chk("ecall.redirect1", 32'(pc_redirect), 32'd1);
    chk("ecall.target", pc_target, 32'h100);
    chk("ecall.trap1", 32'(trap_taken), 32'd1);
    peek("ecall.mepc", 12'h341, 32'h200);
    peek("ecall.mcause", 12'h342, 32'd11);
    peek("ecall.mstatus", 12'h300, 32'h0000_1880);
    drive(1'b1, 32'h100, 1'b0, 32'd0, 1'b1, 1'b0, 2'd0, 12'h000, 32'd0); step("mret");
    chk("mret.redirect1", 32'(pc_redirect), 32'd1);
    chk("mret.target", pc_target, 32'h200);
    chk("mret.trap0", 32'(trap_taken), 32'd0);
    peek("mret.mstatus", 12'h300, 32'h0000_1888);
    drive(1'b0, 32'h200, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 12'h000, 32'd0); step("idle");
    chk("idle.redirect0", 32'(pc_redirect), 32'd0);

    // CSRRS on mscratch, then illegal write to mhartid
    drive(1'b1, 32'h204, 1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 12'h340, 32'hF0); step("wscratch");
    drive(1'b1, 32'h208, 1'b0, 32'd0, 1'b0, 1'b0, 2'd2, 12'h340, 32'h0F);
    #1; chk("csrrs.old", csr_rdata, 32'hF0);
    step("csrrs");
    peek("csrrs.new", 12'h340, 32'hFF);
    drive(1'b1, 32'h20C, 1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 12'hF14, 32'd5);
    #1; chk("ro.illegal", 32'(illegal_csr), 32'd1);
    step("ro");
    chk("ro.trap", 32'(trap_taken), 32'd1);
    peek("ro.mcause", 12'h342, 32'd2);

    // Vectored timer interrupt
    drive(1'b1, 32'h3F0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 12'h305, 32'h101); step("wmtvec");
    drive(1'b1, 32'h3F4, 1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 12'h304, 32'h80); step("wmie");
    drive(1'b1, 32'h3F8, 1'b0, 32'd0, 1'b0, 1'b0, 2'd2, 12'h300, 32'h8); step("setmie2");
    timer_irq = 1'b1;
    drive(1'b1, 32'h400, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 12'h000, 32'd0); step("irq");
    chk("irq.target", pc_target, 32'h11C);
    chk("irq.trap", 32'(trap_taken), 32'd1);
    peek("irq.mcause", 12'h342, 32'h8000_0007);
    peek("irq.mepc", 12'h341, 32'h400);
    timer_irq = 1'b0;

    // WFI with MIE clear: wakes without trapping
    drive(1'b1, 32'h500, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0, 12'h000, 32'd0); step("wfi0");
    chk("wfi0.stall", 32'(stall), 32'd1);
    drive(1'b0, 32'h500, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 12'h000, 32'd0);
    for (int i = 0; i < 10; i++) begin
      step("wfi0wait");
      chk("wfi0wait.stall", 32'(stall), 32'd1);
    end
    timer_irq = 1'b1;
    step("wake0");
    chk("wake0.stall", 32'(stall), 32'd0);
    chk("wake0.trap", 32'(trap_taken), 32'd0);
    timer_irq = 1'b0;

    // WFI with MIE set: wakes into the interrupt handler
    drive(1'b1, 32'h5FC, 1'b0, 32'd0, 1'b0, 1'b0, 2'd2, 12'h300, 32'h8); step("setmie3");
    drive(1'b1, 32'h600, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0, 12'h000, 32'd0); step("wfi1");
    chk("wfi1.stall", 32'(stall), 32'd1);
    timer_irq = 1'b1;
    drive(1'b0, 32'h600, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 12'h000, 32'd0); step("wake1");
    chk("wake1.trap", 32'(trap_taken), 32'd1);
    chk("wake1.target", pc_target, 32'h11C);
    peek("wake1.mepc", 12'h341, 32'h604);
    timer_irq = 1'b0;

    // mcycle low-half rollover
    drive(1'b1, 32'h700, 1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 12'hB80, 32'd0); step("wcych");
    drive(1'b1, 32'h704, 1'b0, 32'd0, 1'b0, 1'b0, 2'd1, 12'hB00, 32'hFFFF_FFFF); step("wcycl");
    drive(1'b0, 32'h708, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 12'h000, 32'd0); step("roll");
    peek("roll.lo", 12'hB00, 32'd0);
    peek("roll.hi", 12'hB80, 32'd1);

    // Asynchronous reset while sleeping
    drive(1'b1, 32'h800, 1'b0, 32'd0, 1'b0, 1'b1, 2'd0, 12'h000, 32'd0); step("wfi2");
    chk("wfi2.stall", 32'(stall), 32'd1);
    drive(1'b0, 32'h800, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 12'h000, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst.stall", 32'(stall), 32'd0);
    chk("arst.target", pc_target, 32'd0);
    chk("arst.redirect", 32'(pc_redirect), 32'd0);
    chk("arst.trap", 32'(trap_taken), 32'd0);
    peek("arst.mtvec", 12'h305, 32'h0000_0100);
    peek("arst.mie", 12'h304, 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      timer_irq = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 9) != 0, $urandom & 32'hFFFF_FFFC, $urandom_range(0, 15) == 0,
            32'($urandom_range(0, 15)), $urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0,
            2'($urandom_range(0, 3)), addrTab[$urandom_range(0, 15)],
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule
